instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 81 ++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program-memory fetch FSM that latches one instruction word and presents its fields to control.
module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [4:0]  opp,
    output logic [2:0]  R1,
    output logic [2:0]  R2,
    output logic [2:0]  QR,
    output logic [1:0]  RES,
    output logic [15:0] pc,
    input  logic        br_valid,
    input  logic [15:0] br_target,
    output logic        halted
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
    state_t state, state_nx;
    logic [15:0] ir, ir_nx, pc_nx;
    logic is_hlt, is_rst;
    assign is_hlt = ir[15:11] == 5'd16;
    assign is_rst = ir[15:11] == 5'd17;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
        end
    end
    // a taken jump outranks both a captured word and a pending handshake
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: begin
                if (br_valid) pc_nx = br_target;
                else if (mem_ack) begin
                    state_nx = ISSUE;
                    ir_nx    = mem_data;
                end
            end
            ISSUE: begin
                if (br_valid) begin
                    state_nx = FETCH;
                    pc_nx    = br_target;
                end else if (is_hlt) state_nx = HALTED;
                else if (is_rst) begin
                    state_nx = FETCH;
                    pc_nx    = '0;
                end else if (dec_ready) begin
                    state_nx = FETCH;
                    pc_nx    = pc + 16'd1;
                end
            end
            default: ;
        endcase
    end
    // HLT and RST words are consumed internally and never shown to control
    always_comb begin
        mem_req   = state == FETCH;
        dec_valid = state == ISSUE && !is_hlt && !is_rst;
        halted    = state == HALTED;
        mem_addr  = pc;
        opp       = ir[15:11];
        R1        = ir[10:8];
        R2        = ir[7:5];
        QR        = ir[4:2];
        RES       = ir[1:0];
    end
endmodule
